// File: rtl/bundle_lit_sequencer_if.sv
// Stimulus/response bundle channel between the literal sequencer and the device it exercises.
// The sequencer drives the stimulus fields and samples the response; the device does the reverse.
interface bundle_lit_sequencer_if;
  logic       stim_valid;
  logic       stim_ready;
  logic [7:0] stim_a;
  logic       stim_b;
  logic [1:0] stim_c;
  logic       resp_valid;
  logic [7:0] resp_a;
  logic       resp_b;
  logic [1:0] resp_c;

  modport master (
    output stim_valid, stim_a, stim_b, stim_c,
    input  stim_ready, resp_valid, resp_a, resp_b, resp_c
  );

  modport slave (
    input  stim_valid, stim_a, stim_b, stim_c,
    output stim_ready, resp_valid, resp_a, resp_b, resp_c
  );
endinterface

// File: rtl/bundle_lit_sequencer.sv
// Issues NUM_VEC arithmetic bundle literals, waits for each echo (bounded by TIMEOUT)
// and tallies mismatches and timeouts into a saturating error count.
module bundle_lit_sequencer #(
  parameter int NUM_VEC = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  bundle_lit_sequencer_if.master  bus,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic                    stop,
  output logic [4:0]              err_count
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEND    = 3'd1,
    WAIT    = 3'd2,
    CHECK   = 3'd3,
    ADVANCE = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(NUM_VEC - 1);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t     state_reg, state_next;
  logic [3:0] idx_reg, idx_next;
  logic [7:0] tmo_reg, tmo_next;
  logic [4:0] err_reg, err_next;
  logic [7:0] cap_a_reg, cap_a_next;
  logic       cap_b_reg, cap_b_next;
  logic [1:0] cap_c_reg, cap_c_next;
  logic       stopped_reg, stopped_next;

  logic [7:0] vec_a;
  logic       vec_b;
  logic [1:0] vec_c;
  logic       mismatch;
  logic [4:0] err_inc;

  // Current literal is derived from the index, so it is stable for as long as SEND lasts.
  always_comb begin
    vec_a    = {4'd0, idx_reg} * 8'd37 + 8'd3;
    vec_b    = idx_reg[0];
    vec_c    = 2'(idx_reg % 4'd3);
    mismatch = (cap_a_reg != vec_a) || (cap_b_reg != vec_b) || (cap_c_reg != vec_c);
    err_inc  = (err_reg == 5'd31) ? err_reg : err_reg + 5'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      idx_reg     <= 4'd0;
      tmo_reg     <= 8'd0;
      err_reg     <= 5'd0;
      cap_a_reg   <= 8'd0;
      cap_b_reg   <= 1'b0;
      cap_c_reg   <= 2'd0;
      stopped_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      tmo_reg     <= tmo_next;
      err_reg     <= err_next;
      cap_a_reg   <= cap_a_next;
      cap_b_reg   <= cap_b_next;
      cap_c_reg   <= cap_c_next;
      stopped_reg <= stopped_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    tmo_next     = tmo_reg;
    err_next     = err_reg;
    cap_a_next   = cap_a_reg;
    cap_b_next   = cap_b_reg;
    cap_c_next   = cap_c_reg;
    stopped_next = stopped_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          idx_next     = 4'd0;
          tmo_next     = 8'd0;
          err_next     = 5'd0;
          stopped_next = 1'b0;
          state_next   = SEND;
        end
      end
      SEND: begin
        if (bus.stim_ready) begin
          tmo_next   = 8'd0;
          state_next = WAIT;
        end
      end
      WAIT: begin
        // A response on the threshold cycle wins over the timeout.
        if (bus.resp_valid) begin
          cap_a_next = bus.resp_a;
          cap_b_next = bus.resp_b;
          cap_c_next = bus.resp_c;
          state_next = CHECK;
        end else if (tmo_reg == TMO_LAST) begin
          err_next   = err_inc;
          state_next = ADVANCE;
        end else begin
          tmo_next = tmo_reg + 8'd1;
        end
      end
      CHECK: begin
        if (mismatch) begin
          err_next = err_inc;
        end
        state_next = ADVANCE;
      end
      ADVANCE: begin
        if (idx_reg == LAST_IDX) begin
          state_next = DONE;
        end else begin
          idx_next   = idx_reg + 4'd1;
          state_next = SEND;
        end
      end
      DONE: begin
        stopped_next = 1'b1;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.stim_valid = (state_reg == SEND);
  assign bus.stim_a     = (state_reg == SEND) ? vec_a : 8'd0;
  assign bus.stim_b     = (state_reg == SEND) ? vec_b : 1'b0;
  assign bus.stim_c     = (state_reg == SEND) ? vec_c : 2'd0;

  assign busy      = (state_reg != IDLE) && (state_reg != DONE);
  assign done      = (state_reg == DONE);
  assign pass      = (state_reg == DONE) && (err_reg == 5'd0);
  assign stop      = (state_reg == DONE) && !stopped_reg;
  assign err_count = err_reg;

endmodule

// File: tb/tb_bundle_lit_sequencer.sv
// Drives the sequencer with a scripted/randomised echo device and compares against
// per-vector expectations computed from the literal formulas and cycle-budget arithmetic.
module tb_bundle_lit_sequencer;
  localparam int NUM_VEC = 4;
  localparam int TIMEOUT = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, pass, stop;
  logic [4:0] err_count;

  always #5 clock = ~clock;

  bundle_lit_sequencer_if bus();

  bundle_lit_sequencer #(.NUM_VEC(NUM_VEC), .TIMEOUT(TIMEOUT)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .stop      (stop),
    .err_count (err_count)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int stop_seen   = 0;

  // Per-vector device behaviour for the next run.
  int         rdly  [NUM_VEC];
  int         wdly  [NUM_VEC];
  logic [7:0] xa    [NUM_VEC];
  logic       xb    [NUM_VEC];
  logic [1:0] xc    [NUM_VEC];
  bit         stray [NUM_VEC];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_a(input int i);
    return 8'((i * 37 + 3) % 256);
  endfunction
  function automatic logic exp_b(input int i);
    return 1'(i % 2);
  endfunction
  function automatic logic [1:0] exp_c(input int i);
    return 2'(i % 3);
  endfunction

  // Cycles from SEND entry of vector 0 to DONE entry.
  function automatic int model_cycles();
    int total = 0;
    for (int v = 0; v < NUM_VEC; v++) begin
      total += rdly[v] + 1;
      total += (wdly[v] < TIMEOUT) ? wdly[v] + 2 : TIMEOUT;
      total += 1;
    end
    return total;
  endfunction

  task automatic step();
    @(negedge clock);
    cyc++;
    if (stop) stop_seen++;
  endtask

  task automatic clear_cfg();
    for (int v = 0; v < NUM_VEC; v++) begin
      rdly[v] = 0; wdly[v] = 0; xa[v] = 8'd0; xb[v] = 1'b0; xc[v] = 2'd0; stray[v] = 1'b0;
    end
  endtask

  task automatic check_fields(input int v);
    check_eq("stim_a", 32'(bus.stim_a), 32'(exp_a(v)));
    check_eq("stim_b", 32'(bus.stim_b), 32'(exp_b(v)));
    check_eq("stim_c", 32'(bus.stim_c), 32'(exp_c(v)));
  endtask

  task automatic check_all_low(input string tag);
    check_eq({tag, "_busy"},  32'(busy), 0);
    check_eq({tag, "_done"},  32'(done), 0);
    check_eq({tag, "_pass"},  32'(pass), 0);
    check_eq({tag, "_stop"},  32'(stop), 0);
    check_eq({tag, "_err"},   32'(err_count), 0);
    check_eq({tag, "_valid"}, 32'(bus.stim_valid), 0);
    check_eq({tag, "_a"},     32'(bus.stim_a), 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic run_seq(input int run_id, input int reset_vec, input bit hold_start);
    int exp_err = 0;
    int exp_cyc;
    exp_cyc = model_cycles();
    bus.stim_ready = 1'b0;
    bus.resp_valid = 1'b0;
    check_all_low("idle");
    start = 1'b1;
    step();
    start = hold_start;
    cyc = 0;
    stop_seen = 0;
    for (int v = 0; v < NUM_VEC; v++) begin
      check_eq("send_valid", 32'(bus.stim_valid), 1);
      check_eq("send_busy", 32'(busy), 1);
      check_fields(v);
      check_eq("err_so_far", 32'(err_count), 32'(exp_err));
      for (int k = 0; k < rdly[v]; k++) begin
        if (stray[v] && k == 0) begin
          bus.resp_a = 8'hA5; bus.resp_b = 1'b1; bus.resp_c = 2'd3; bus.resp_valid = 1'b1;
        end
        step();
        bus.resp_valid = 1'b0;
        check_eq("hold_valid", 32'(bus.stim_valid), 1);
        check_fields(v);
      end
      bus.stim_ready = 1'b1;
      step();
      bus.stim_ready = 1'b0;
      check_eq("wait_valid", 32'(bus.stim_valid), 0);
      if (v == reset_vec) begin
        start = 1'b0;
        #2 reset = 1'b0;
        #1 check_all_low("async_rst");
        step();
        reset = 1'b1;
        step();
        step();
        check_all_low("no_resume");
        $display("run %0d: reset in WAIT of vector %0d", run_id, v);
        return;
      end
      if (wdly[v] < TIMEOUT) begin
        repeat (wdly[v]) step();
        bus.resp_a = exp_a(v) ^ xa[v];
        bus.resp_b = exp_b(v) ^ xb[v];
        bus.resp_c = exp_c(v) ^ xc[v];
        bus.resp_valid = 1'b1;
        step();
        bus.resp_valid = 1'b0;
        if (stray[v]) begin
          bus.resp_a = ~bus.resp_a; bus.resp_valid = 1'b1;
        end
        step();
        bus.resp_valid = 1'b0;
        if (xa[v] != 8'd0 || xb[v] != 1'b0 || xc[v] != 2'd0) exp_err++;
      end else begin
        repeat (TIMEOUT) step();
        check_eq("tmo_adv_valid", 32'(bus.stim_valid), 0);
        check_eq("tmo_adv_busy", 32'(busy), 1);
        exp_err++;
      end
      step();
    end
    check_eq("stop_pulse", 32'(stop), 1);
    check_eq("done", 32'(done), 1);
    check_eq("done_busy", 32'(busy), 0);
    check_eq("latency", 32'(cyc), 32'(exp_cyc));
    check_eq("final_err", 32'(err_count), 32'(exp_err));
    check_eq("final_pass", 32'(pass), 32'(exp_err == 0));
    start = 1'b1;
    step();
    check_eq("stop_once", 32'(stop), 0);
    step();
    check_eq("done_held", 32'(done), 1);
    check_eq("stop_count", 32'(stop_seen), 1);
    start = 1'b0;
    $display("run %0d: cycles=%0d err=%0d pass=%0d", run_id, cyc, err_count, pass);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int run_id = 0;
    bus.stim_ready = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_a = 8'd0; bus.resp_b = 1'b0; bus.resp_c = 2'd0;
    #1 check_all_low("por");
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    clear_cfg();                    run_seq(run_id++, -1, 1'b0); do_reset();
    clear_cfg(); xa[2] = 8'd1;      run_seq(run_id++, -1, 1'b1); do_reset();
    clear_cfg(); wdly[1] = TIMEOUT; run_seq(run_id++, -1, 1'b0); do_reset();
    clear_cfg(); rdly[0] = 5;       run_seq(run_id++, -1, 1'b0); do_reset();
    clear_cfg();                    run_seq(run_id++, 2, 1'b0);
    clear_cfg();                    run_seq(run_id++, -1, 1'b0); do_reset();
    clear_cfg(); rdly[1] = 2; stray[1] = 1'b1; run_seq(run_id++, -1, 1'b0); do_reset();
    clear_cfg(); wdly[3] = TIMEOUT - 1; run_seq(run_id++, -1, 1'b0); do_reset();

    for (int r = 0; r < 25; r++) begin
      clear_cfg();
      for (int v = 0; v < NUM_VEC; v++) begin
        rdly[v] = $urandom_range(0, 3);
        case ($urandom_range(0, 5))
          4:       wdly[v] = TIMEOUT - 1;
          5:       wdly[v] = TIMEOUT;
          default: wdly[v] = $urandom_range(0, 3);
        endcase
        if ($urandom_range(0, 3) == 0) begin
          case ($urandom_range(0, 2))
            0:       xa[v] = 8'(1 << $urandom_range(0, 7));
            1:       xb[v] = 1'b1;
            default: xc[v] = 2'($urandom_range(1, 3));
          endcase
        end
        stray[v] = 1'($urandom_range(0, 1));
      end
      run_seq(run_id++, -1, 1'($urandom_range(0, 1)));
      do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
